clock24_multimode: RTL

- Parametrised successor of the 24-hour time-of-day counter.
- Adds:
  - an internal seconds prescaler, so the block runs from the system clock
  - run/pause control
  - validated load
  - per-field set buttons
  - 12/24-hour display conversion with a PM flag
  - an HH:MM alarm
  - status pulses
- Sits between the board clock/button debouncers and the 7-segment display driver.

---
 rtl/clock24_multimode.sv | 136 +++++++++++++
 1 files changed

// File: rtl/clock24_multimode.sv
// clock24_multimode: time-of-day counter (HH:MM:SS, 24-hour) driven from the
// system clock through a seconds prescaler. Supports pause, validated load,
// hour/minute set buttons, a 12-hour display view, an HH:MM alarm and
// single-cycle status pulses.
//
// Priority on each rising edge: reset > start > (inc_hour | inc_min) > tick.
// A tick is an edge with run=1 and the prescaler at TICK_DIV-1. All pulse
// outputs are registered, so they go high in the same cycle as the new time.
module clock24_multimode #(
  parameter int TICK_DIV = 100000000,
  parameter int CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [4:0] hours_i,
  input  logic [5:0] mins_i,
  input  logic [5:0] secs_i,
  input  logic       run,
  input  logic       inc_hour,
  input  logic       inc_min,
  input  logic       mode12,
  input  logic       alarm_en,
  input  logic [4:0] alarm_h,
  input  logic [5:0] alarm_m,
  output logic [4:0] hours_o,
  output logic [5:0] mins_o,
  output logic [5:0] secs_o,
  output logic [4:0] disp_hours_o,
  output logic       pm_o,
  output logic       sec_tick_o,
  output logic       day_wrap_o,
  output logic       alarm_o,
  output logic       load_err_o
);

  localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] presc;
  logic             tick;
  logic             load_ok;
  logic [4:0]       adv_h;
  logic [5:0]       adv_m;
  logic [5:0]       adv_s;
  logic             adv_wrap;
  logic             adv_alarm;

  assign tick    = run && (presc == PRESC_LAST);
  assign load_ok = (hours_i <= 5'd23) && (mins_i <= 6'd59) && (secs_i <= 6'd59);

  // Time one second after the current value, with the carry chain resolved.
  always_comb begin
    adv_h    = hours_o;
    adv_m    = mins_o;
    adv_s    = secs_o + 6'd1;
    adv_wrap = 1'b0;
    if (secs_o == 6'd59) begin
      adv_s = 6'd0;
      adv_m = mins_o + 6'd1;
      if (mins_o == 6'd59) begin
        adv_m = 6'd0;
        if (hours_o == 5'd23) begin
          adv_h    = 5'd0;
          adv_wrap = 1'b1;
        end else begin
          adv_h = hours_o + 5'd1;
        end
      end
    end
    // Out-of-range alarm settings can never equal a legal advanced time.
    adv_alarm = alarm_en && (adv_h == alarm_h) && (adv_m == alarm_m) && (adv_s == 6'd0);
  end

  // Time, prescaler and pulse registers, in edge priority order.
  always_ff @(posedge clk) begin
    if (reset) begin
      hours_o    <= '0;
      mins_o     <= '0;
      secs_o     <= '0;
      presc      <= '0;
      sec_tick_o <= 1'b0;
      day_wrap_o <= 1'b0;
      alarm_o    <= 1'b0;
      load_err_o <= 1'b0;
    end else begin
      sec_tick_o <= 1'b0;
      day_wrap_o <= 1'b0;
      alarm_o    <= 1'b0;
      load_err_o <= 1'b0;
      if (start) begin
        if (load_ok) begin
          hours_o <= hours_i;
          mins_o  <= mins_i;
          secs_o  <= secs_i;
          presc   <= '0;
        end else begin
          load_err_o <= 1'b1;
        end
      end else if (inc_hour || inc_min) begin
        // A tick landing on a set-button edge is dropped entirely.
        if (inc_hour) hours_o <= (hours_o == 5'd23) ? 5'd0 : hours_o + 5'd1;
        if (inc_min) begin
          mins_o <= (mins_o == 6'd59) ? 6'd0 : mins_o + 6'd1;
          secs_o <= '0;
          presc  <= '0;
        end else if (run) begin
          presc <= tick ? '0 : presc + 1'b1;
        end
      end else if (run) begin
        if (tick) begin
          presc      <= '0;
          hours_o    <= adv_h;
          mins_o     <= adv_m;
          secs_o     <= adv_s;
          sec_tick_o <= 1'b1;
          day_wrap_o <= adv_wrap;
          alarm_o    <= adv_alarm;
        end else begin
          presc <= presc + 1'b1;
        end
      end
    end
  end

  // Display view of the hour register; never feeds back into counting.
  always_comb begin
    disp_hours_o = hours_o;
    pm_o         = 1'b0;
    if (mode12) begin
      pm_o = (hours_o >= 5'd12);
      if (hours_o == 5'd0)      disp_hours_o = 5'd12;
      else if (hours_o > 5'd12) disp_hours_o = hours_o - 5'd12;
    end
  end

endmodule
